// File: rtl/iq_symbol_framer_pkg.sv
// Shared constants, FSM encoding and the saturation helper for the IQ symbol framer.
package iq_symbol_framer_pkg;

   localparam int unsigned GAIN_UNITY = 16384;
   localparam int unsigned GAIN_SHIFT = 14;

   typedef enum logic {
      S_DATA  = 1'b0,
      S_GUARD = 1'b1
   } state_t;

   // Clamps a sign-extended value to the signed range of a 'width'-bit word.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned        width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      else
         return value;
   endfunction

endpackage

// File: rtl/iq_symbol_framer_gain_sat.sv
// One signed component: multiply by Q1.14 gain, shift, saturate; two-stage valid pipeline.
module iq_gain_sat
   import iq_symbol_framer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned GAIN_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic                         srst,
   input  logic                         s1_adv,
   input  logic                         s2_adv,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic signed [GAIN_WIDTH-1:0] gain,
   output logic                         s1_valid,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] out_data
);

   localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH;

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;
   logic signed [63:0]   clamped;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         s1_valid <= 1'b0;
         prod     <= '0;
      end else if (srst) begin
         s1_valid <= 1'b0;
         prod     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         prod     <= PW'(in_data) * PW'(gain);
      end
   end

   always_comb begin
      shifted = prod >>> GAIN_SHIFT;
      clamped = sat_signed(64'(shifted), DATA_WIDTH);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (srst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         out_data  <= DATA_WIDTH'(clamped);
      end
   end

endmodule

// File: rtl/iq_symbol_framer.sv
// Gains, saturates and packs I/Q samples; frames SYMB_LEN data words plus GUARD_LEN zero words.
module iq_symbol_framer
   import iq_symbol_framer_pkg::*;
#(
   parameter int unsigned SIN_COS_WIDTH = 16,
   parameter int unsigned GAIN_WIDTH    = 16,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter int unsigned SYMB_LEN      = 1280,
   parameter int unsigned GUARD_LEN     = 64
) (
   input  logic                            clk,
   input  logic                            aresetn,
   input  logic                            srst,
   input  logic signed [GAIN_WIDTH-1:0]    gain,
   input  logic                            in_tvalid,
   output logic                            in_tready,
   input  logic                            in_tlast,
   input  logic signed [SIN_COS_WIDTH-1:0] in_sin,
   input  logic signed [SIN_COS_WIDTH-1:0] in_cos,
   output logic                            out_tvalid,
   input  logic                            out_tready,
   output logic                            out_tlast,
   output logic                            out_tuser,
   output logic [2*SIN_COS_WIDTH-1:0]      out_tdata,
   output logic [CNT_WIDTH-1:0]            frame_count,
   output logic                            err_tlast
);

   localparam logic [CNT_WIDTH-1:0] SYMB_LAST  = CNT_WIDTH'(SYMB_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'(GUARD_LEN - 1);

   state_t                         state_q, state_d;
   logic [CNT_WIDTH-1:0]           samp_cnt, guard_cnt;
   logic signed [GAIN_WIDTH-1:0]   gain_q, gain_sel;
   logic                           accept, src_valid, src_last, src_user;
   logic signed [SIN_COS_WIDTH-1:0] src_sin, src_cos, i_data, q_data;
   logic                           s1_last, s1_user, s2_last, s2_user;
   logic                           s1_valid_i, s1_valid_q, out_valid_i, out_valid_q;
   logic                           s1_valid, s1_adv, s2_adv;

   // Both lanes share the same handshakes, so their valid bits always agree.
   assign s1_valid   = s1_valid_i & s1_valid_q;
   assign out_tvalid = out_valid_i & out_valid_q;
   assign s2_adv     = !out_tvalid || out_tready;
   assign s1_adv     = !s1_valid || s2_adv;

   always_comb begin
      state_d   = state_q;
      in_tready = 1'b0;
      accept    = 1'b0;
      src_valid = 1'b0;
      src_last  = 1'b0;
      src_user  = 1'b0;
      unique case (state_q)
         S_DATA: begin
            in_tready = s1_adv && aresetn && !srst;
            accept    = in_tready && in_tvalid;
            src_valid = accept;
            if (accept && samp_cnt == SYMB_LAST) begin
               if (GUARD_LEN > 0)
                  state_d = S_GUARD;
               else
                  src_last = 1'b1;
            end
         end
         S_GUARD: begin
            src_valid = s1_adv;
            src_user  = 1'b1;
            if (s1_adv && guard_cnt == GUARD_LAST) begin
               src_last = 1'b1;
               state_d  = S_DATA;
            end
         end
         default: state_d = S_DATA;
      endcase
   end

   // The first sample of a symbol uses the live gain; the rest use the copy latched with it.
   always_comb begin
      gain_sel = (samp_cnt == '0) ? gain : gain_q;
      src_sin  = src_user ? '0 : in_sin;
      src_cos  = src_user ? '0 : in_cos;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_DATA;
      end else if (srst) begin
         state_q <= S_DATA;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         samp_cnt    <= '0;
         guard_cnt   <= '0;
         gain_q      <= GAIN_WIDTH'(GAIN_UNITY);
         err_tlast   <= 1'b0;
         frame_count <= '0;
         s1_last     <= 1'b0;
         s1_user     <= 1'b0;
         s2_last     <= 1'b0;
         s2_user     <= 1'b0;
      end else if (srst) begin
         samp_cnt    <= '0;
         guard_cnt   <= '0;
         gain_q      <= GAIN_WIDTH'(GAIN_UNITY);
         err_tlast   <= 1'b0;
         frame_count <= '0;
         s1_last     <= 1'b0;
         s1_user     <= 1'b0;
         s2_last     <= 1'b0;
         s2_user     <= 1'b0;
      end else begin
         if (accept) begin
            samp_cnt <= (samp_cnt == SYMB_LAST) ? '0 : samp_cnt + CNT_WIDTH'(1);
            if (samp_cnt == '0)
               gain_q <= gain;
            if (in_tlast && samp_cnt != SYMB_LAST)
               err_tlast <= 1'b1;
         end
         if (state_q == S_GUARD && s1_adv)
            guard_cnt <= (guard_cnt == GUARD_LAST) ? '0 : guard_cnt + CNT_WIDTH'(1);
         if (s1_adv) begin
            s1_last <= src_last;
            s1_user <= src_user;
         end
         if (s2_adv) begin
            s2_last <= s1_last;
            s2_user <= s1_user;
         end
         if (out_tvalid && out_tready && out_tlast)
            frame_count <= frame_count + CNT_WIDTH'(1);
      end
   end

   iq_gain_sat #(.DATA_WIDTH(SIN_COS_WIDTH), .GAIN_WIDTH(GAIN_WIDTH)) u_gain_i (
      .clk      (clk),
      .aresetn  (aresetn),
      .srst     (srst),
      .s1_adv   (s1_adv),
      .s2_adv   (s2_adv),
      .in_valid (src_valid),
      .in_data  (src_cos),
      .gain     (gain_sel),
      .s1_valid (s1_valid_i),
      .out_valid(out_valid_i),
      .out_data (i_data)
   );

   iq_gain_sat #(.DATA_WIDTH(SIN_COS_WIDTH), .GAIN_WIDTH(GAIN_WIDTH)) u_gain_q (
      .clk      (clk),
      .aresetn  (aresetn),
      .srst     (srst),
      .s1_adv   (s1_adv),
      .s2_adv   (s2_adv),
      .in_valid (src_valid),
      .in_data  (src_sin),
      .gain     (gain_sel),
      .s1_valid (s1_valid_q),
      .out_valid(out_valid_q),
      .out_data (q_data)
   );

   assign out_tlast = s2_last;
   assign out_tuser = s2_user;
   assign out_tdata = {i_data, q_data};

endmodule

// File: doc/iq_symbol_framer.md
Name: iq_symbol_framer

Overview:
- Downstream neighbour of the multi-tone DDS signal generator; consumes its sin/cos AXI-Stream sample flow.
- Applies a runtime gain with saturation and packs samples as {I=cos, Q=sin} 32-bit words.
- Delimits each symbol of SYMB_LEN samples, appends GUARD_LEN zero samples, and marks the frame end with tlast.
- Output feeds the radio TX sample path.

Parameters:
- SIN_COS_WIDTH, 16, width of each I/Q component in and out.
- GAIN_WIDTH, 16, signed gain width, Q1.14 format (16384 = unity).
- CNT_WIDTH, 16, width of the sample/guard/frame counters.
- SYMB_LEN, 1280, data samples per symbol (1..2^CNT_WIDTH-1).
- GUARD_LEN, 64, zero samples appended per symbol (0 allowed).

Ports:
- clk  in  1  sample clock.
- aresetn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous clear, active high; same effect as reset.
- gain  in  GAIN_WIDTH  signed Q1.14 gain; sampled at symbol start.
- in_tvalid  in  1  upstream sample valid.
- in_tready  out  1  upstream ready.
- in_tlast  in  1  upstream tlast; checked only, never used for framing.
- in_sin  in  SIN_COS_WIDTH  Q sample, signed.
- in_cos  in  SIN_COS_WIDTH  I sample, signed.
- out_tvalid  out  1  output valid.
- out_tready  in  1  downstream ready.
- out_tlast  out  1  last word of symbol+guard frame.
- out_tuser  out  1  1 = guard (zero) sample.
- out_tdata  out  2*SIN_COS_WIDTH  {I, Q}, I in the MSBs.
- frame_count  out  CNT_WIDTH  completed frames; wraps modulo 2^CNT_WIDTH.
- err_tlast  out  1  sticky: in_tlast disagreed with the internal symbol boundary.

Behaviour:
- Reset (aresetn=0 async, or srst=1 sync) clears everything:
  - state=S_DATA; all counters 0; pipeline valids 0; latched gain=16384.
  - Outputs: out_tvalid=0, out_tlast=0, out_tuser=0, out_tdata=0, frame_count=0, err_tlast=0, in_tready=0 while aresetn=0.
- Reset mid-frame discards all in-flight samples; the next accepted sample is sample 0 of a new symbol.
- Pipeline: stage1 (source mux + multiply), stage2 (shift/saturate + output register).
  - Latency is 2 cycles from an accepted input or a generated guard sample to out_tvalid, assuming no stall.
  - Throughput is 1 word/clk.
  - A stage advances when its successor is empty or is being consumed (out_tready for stage2).
  - Valid samples are never dropped or duplicated under backpressure.
  - out_tdata/tlast/tuser are held stable while out_tvalid=1 and out_tready=0.
- FSM states:
  - S_DATA: in_tready = stage1 can advance.
    - Each accepted sample increments samp_cnt; gain is latched when samp_cnt==0.
    - On acceptance with samp_cnt==SYMB_LEN-1: samp_cnt=0, then go to S_GUARD if GUARD_LEN>0, else stay in S_DATA and tag the word tlast.
  - S_GUARD: in_tready=0.
    - Injects zero samples (tuser=1) into stage1 whenever it can advance; guard_cnt counts 0..GUARD_LEN-1.
    - The last guard word is tagged tlast; then return to S_DATA.
- Arithmetic:
  - Products are signed SIN_COS_WIDTH x GAIN_WIDTH, full width, then arithmetic shift right by 14.
  - Results saturate to [-2^(SIN_COS_WIDTH-1), 2^(SIN_COS_WIDTH-1)-1].
  - Guard samples bypass the gain and are exactly 0.
- frame_count increments when a tlast word is consumed (out_tvalid & out_tready & out_tlast).
- err_tlast is set, and held until reset, on any accepted sample where in_tlast=1 and samp_cnt!=SYMB_LEN-1.
- A gain change mid-symbol has no effect until the next symbol start.

Decomposition:
- Shared package holds:
  - the Q1.14 unity constant (16384) and shift amount (14);
  - the FSM state encoding (S_DATA, S_GUARD);
  - the saturation helper function.
- One sub-module, iq_gain_sat: a single-component signed multiply/shift/saturate with a valid/enable pipeline, instantiated twice (I and Q).

Test Plan:
- Unity gain, SYMB_LEN=4, GUARD_LEN=2, continuous input cos=100, sin=-200, out_tready=1:
  - first out_tvalid appears 2 cycles after the first accept;
  - words are 4x{100,-200} then 2x{0,0} with tuser=1;
  - tlast on the 6th word; frame_count=1.
- Gain=32767, cos=32767, sin=-32768:
  - I saturates to 32767 and Q to -32768;
  - gain=8192 with cos=1000 gives I=500.
- Random out_tready with a 30% stall rate over 100 frames:
  - the output sequence equals the reference model exactly;
  - no losses or duplicates; data held during stalls.
- GUARD_LEN=0: tlast lands on every 4th data word, and in_tready never drops with out_tready=1.
- Drive in_tlast on sample 2 of 4 -> err_tlast=1 and sticky; framing is unchanged.
- Assert srst, then aresetn, mid-guard -> outputs go to reset values; the next accepted sample starts a new symbol and frame_count restarts at 0.
